// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings, the default-slave state type and the
// address-window decode helper used by ahb_dec_mux.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Decode operands are widened to this so one function serves any ADDR_W.
  localparam int DEC_AW_MAX = 64;

  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_e;

  function automatic logic ahb_decode(input logic [DEC_AW_MAX-1:0] addr,
                                      input logic [DEC_AW_MAX-1:0] base,
                                      input logic [DEC_AW_MAX-1:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// ahb_default_slave: answers unmapped/denied transfers with the two-cycle
// AHB ERROR response (hready=0/ERROR, then hready=1/ERROR).
// Ports: pll_core_cpuclk clock, pad_cpu_rst sync active-high reset,
//        req   accepted address phase that no slave will take,
//        hready/hresp  response while the default slave owns the data phase.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic       pll_core_cpuclk,
  input  logic       pad_cpu_rst,
  input  logic       req,
  output logic       hready,
  output logic [1:0] hresp
);

  ds_state_e state, state_nxt;

  always_ff @(posedge pll_core_cpuclk) begin
    if (pad_cpu_rst) state <= DS_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hready    = 1'b1;
    hresp     = HRESP_OKAY;
    case (state)
      DS_IDLE: if (req) state_nxt = DS_ERR1;
      DS_ERR1: begin
        hready    = 1'b0;
        hresp     = HRESP_ERROR;
        state_nxt = DS_ERR2;
      end
      DS_ERR2: begin
        hresp     = HRESP_ERROR;
        // ERR2 completes with hready=1, so a new request can be accepted now.
        state_nxt = req ? DS_ERR1 : DS_IDLE;
      end
      default: state_nxt = DS_IDLE;
    endcase
  end

endmodule

// File: rtl/ahb_dec_mux.sv
// ahb_dec_mux: single-master AHB-Lite address decoder + response mux with
// NUM_SLV mask/base windows and a built-in ERROR default slave.
// Ports: m_* master side (address/control/wdata in, hrdata/hready/hresp out),
//        smpu_deny MPU veto of the current address phase,
//        s_hsel per-slave select, s_* broadcast address/control/wdata,
//        s_hreadyin (= m_hready), s_hrdata/s_hready/s_hresp packed per slave.
// Option: define AHB_DEC_MUX_TIMEOUT_EN to add a stall watchdog that errors a
//         hung slave after TIMEOUT_CYC wait cycles and fences it off (orphan)
//         until it next drives hready high.
module ahb_dec_mux
  import ahb_pkg::*;
#(
  parameter int NUM_SLV = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE =
    {32'h00000000, 32'h20000000, 32'h40000000, 32'h60000000},
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK =
    {32'hFFF80000, 32'hFF800000, 32'hF0000000, 32'hFFF00000},
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                      pll_core_cpuclk,
  input  logic                      pad_cpu_rst,
  input  logic [ADDR_W-1:0]         m_haddr,
  input  logic [1:0]                m_htrans,
  input  logic                      m_hwrite,
  input  logic [2:0]                m_hsize,
  input  logic [2:0]                m_hburst,
  input  logic [3:0]                m_hprot,
  input  logic [DATA_W-1:0]         m_hwdata,
  input  logic                      smpu_deny,
  output logic [DATA_W-1:0]         m_hrdata,
  output logic                      m_hready,
  output logic [1:0]                m_hresp,
  output logic [NUM_SLV-1:0]        s_hsel,
  output logic [ADDR_W-1:0]         s_haddr,
  output logic [1:0]                s_htrans,
  output logic                      s_hwrite,
  output logic [2:0]                s_hsize,
  output logic [2:0]                s_hburst,
  output logic [3:0]                s_hprot,
  output logic [DATA_W-1:0]         s_hwdata,
  output logic                      s_hreadyin,
  input  logic [NUM_SLV*DATA_W-1:0] s_hrdata,
  input  logic [NUM_SLV-1:0]        s_hready,
  input  logic [NUM_SLV*2-1:0]      s_hresp
);

  logic [NUM_SLV-1:0] hit, hit_pri, orphan;
  logic [NUM_SLV:0]   dsel;          // bit NUM_SLV = default slave
  logic               acc, dflt_req;
  logic               ds_hready;
  logic [1:0]         ds_hresp;
  logic               to_hit, to_err2;

  // Window decode; lowest index wins on overlap.
  always_comb begin
    logic [DEC_AW_MAX-1:0] addr_x, base_x, mask_x;
    logic                  found;
    addr_x = '0;
    addr_x[ADDR_W-1:0] = m_haddr;
    found  = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      base_x = '0;
      mask_x = '0;
      base_x[ADDR_W-1:0] = SLV_BASE[i*ADDR_W +: ADDR_W];
      mask_x[ADDR_W-1:0] = SLV_MASK[i*ADDR_W +: ADDR_W];
      hit[i]     = ahb_decode(addr_x, base_x, mask_x);
      hit_pri[i] = hit[i] & ~found;
      found      = found | hit[i];
    end
  end

  // An orphaned slave is not re-selected; its window falls to the default slave.
  assign s_hsel   = {NUM_SLV{m_htrans[1] & ~smpu_deny}} & hit_pri & ~orphan;
  assign acc      = m_htrans[1] & m_hready;
  assign dflt_req = acc & ~|s_hsel;

  // Data-phase owner; advances only when the current data phase completes.
  always_ff @(posedge pll_core_cpuclk) begin
    if (pad_cpu_rst)   dsel <= '0;
    else if (m_hready) dsel <= acc ? {dflt_req, s_hsel} : '0;
  end

  ahb_default_slave u_dflt (
    .pll_core_cpuclk (pll_core_cpuclk),
    .pad_cpu_rst     (pad_cpu_rst),
    .req             (dflt_req),
    .hready          (ds_hready),
    .hresp           (ds_hresp)
  );

  always_comb begin
    m_hready = 1'b1;
    m_hresp  = HRESP_OKAY;
    m_hrdata = '0;
    if (dsel[NUM_SLV]) begin
      m_hready = ds_hready;
      m_hresp  = ds_hresp;
    end
    for (int i = 0; i < NUM_SLV; i++) begin
      if (dsel[i]) begin
        m_hrdata = s_hrdata[i*DATA_W +: DATA_W];
        m_hready = s_hready[i];
        m_hresp  = s_hresp[i*2 +: 2];
      end
    end
    // Watchdog override of a hung slave: ERROR cycle 1 then cycle 2.
    if (to_hit) begin
      m_hready = 1'b0;
      m_hresp  = HRESP_ERROR;
      m_hrdata = '0;
    end
    if (to_err2) begin
      m_hready = 1'b1;
      m_hresp  = HRESP_ERROR;
      m_hrdata = '0;
    end
  end

`ifdef AHB_DEC_MUX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] to_cnt;
  logic             ext_sel;

  assign ext_sel = |dsel[NUM_SLV-1:0];
  assign to_hit  = ext_sel & (to_cnt == CNT_W'(TIMEOUT_CYC));

  always_ff @(posedge pll_core_cpuclk) begin
    if (pad_cpu_rst) begin
      to_cnt  <= '0;
      to_err2 <= 1'b0;
      orphan  <= '0;
    end else begin
      to_err2 <= to_hit;
      if (m_hready || to_hit) to_cnt <= '0;
      else if (ext_sel)       to_cnt <= to_cnt + 1'b1;
      for (int i = 0; i < NUM_SLV; i++) begin
        if (to_hit && dsel[i]) orphan[i] <= 1'b1;
        else if (s_hready[i])  orphan[i] <= 1'b0;
      end
    end
  end
`else
  assign orphan  = '0;
  assign to_hit  = 1'b0;
  assign to_err2 = 1'b0;
`endif

  assign s_haddr    = m_haddr;
  assign s_htrans   = m_htrans;
  assign s_hwrite   = m_hwrite;
  assign s_hsize    = m_hsize;
  assign s_hburst   = m_hburst;
  assign s_hprot    = m_hprot;
  assign s_hwdata   = m_hwdata;
  assign s_hreadyin = m_hready;

endmodule

// File: tb/tb_ahb_dec_mux.sv
module tb_ahb_dec_mux;
  import ahb_pkg::*;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] m_haddr;
  logic [1:0]    m_htrans;
  logic          m_hwrite;
  logic [2:0]    m_hsize, m_hburst;
  logic [3:0]    m_hprot;
  logic [DW-1:0] m_hwdata;
  logic          smpu_deny;
  logic [DW-1:0] m_hrdata;
  logic          m_hready;
  logic [1:0]    m_hresp;
  logic [NS-1:0] s_hsel;
  logic [AW-1:0] s_haddr;
  logic [1:0]    s_htrans;
  logic          s_hwrite;
  logic [2:0]    s_hsize, s_hburst;
  logic [3:0]    s_hprot;
  logic [DW-1:0] s_hwdata;
  logic          s_hreadyin;
  logic [NS*DW-1:0] s_hrdata;
  logic [NS-1:0]    s_hready;
  logic [NS*2-1:0]  s_hresp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ahb_dec_mux #(.NUM_SLV(NS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(8)) dut (
    .pll_core_cpuclk (clk),       .pad_cpu_rst (rst),
    .m_haddr   (m_haddr),   .m_htrans (m_htrans), .m_hwrite (m_hwrite),
    .m_hsize   (m_hsize),   .m_hburst (m_hburst), .m_hprot  (m_hprot),
    .m_hwdata  (m_hwdata),  .smpu_deny (smpu_deny),
    .m_hrdata  (m_hrdata),  .m_hready (m_hready), .m_hresp  (m_hresp),
    .s_hsel    (s_hsel),    .s_haddr  (s_haddr),  .s_htrans (s_htrans),
    .s_hwrite  (s_hwrite),  .s_hsize  (s_hsize),  .s_hburst (s_hburst),
    .s_hprot   (s_hprot),   .s_hwdata (s_hwdata), .s_hreadyin (s_hreadyin),
    .s_hrdata  (s_hrdata),  .s_hready (s_hready), .s_hresp  (s_hresp)
  );

  function automatic logic [31:0] sdat(input int i);
    return 32'hD000_0000 | (32'(i + 1) * 32'h0000_1111);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, expv, $time);
    end
  endtask

  // Drive one address-phase cycle just after the rising edge.
  task automatic nxt(input logic [31:0] a, input logic [1:0] t, input logic d);
    @(posedge clk); #1;
    m_haddr = a; m_htrans = t; smpu_deny = d; m_hwrite = 1'b0;
  endtask

  // Sample mid-cycle and compare select + master response.
  task automatic exp_cyc(input string nm, input logic [NS-1:0] hsel, input logic rdy,
                         input logic [1:0] resp, input logic [31:0] rdata);
    @(negedge clk);
    chk({nm, ".hsel"},   64'(s_hsel),   64'(hsel));
    chk({nm, ".hready"}, 64'(m_hready), 64'(rdy));
    chk({nm, ".hresp"},  64'(m_hresp),  64'(resp));
    chk({nm, ".hrdata"}, 64'(m_hrdata), 64'(rdata));
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        deny;
    int          slv;    // expected selected slave, -1 = none
  } vec_t;

  typedef struct {
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  vec_t vt[15];
  exp_t sb[$];

  initial begin
    exp_t e;
    rst = 1'b1; m_haddr = '0; m_htrans = HTRANS_IDLE; m_hwrite = 1'b0;
    m_hsize = 3'd2; m_hburst = 3'd0; m_hprot = 4'h3; m_hwdata = 32'hCAFE_0001;
    smpu_deny = 1'b0; s_hready = '1; s_hresp = '0;
    for (int i = 0; i < NS; i++) s_hrdata[i*DW +: DW] = sdat(i);

    vt[0]  = '{32'h6000_0010, HTRANS_NONSEQ, 1'b0,  0};
    vt[1]  = '{32'h4000_0020, HTRANS_SEQ,    1'b0,  1};
    vt[2]  = '{32'h2000_0004, HTRANS_NONSEQ, 1'b0,  2};
    vt[3]  = '{32'h0000_0008, HTRANS_NONSEQ, 1'b0,  3};
    vt[4]  = '{32'h1000_0000, HTRANS_NONSEQ, 1'b0, -1};
    vt[5]  = '{32'h2000_0000, HTRANS_NONSEQ, 1'b1, -1};
    vt[6]  = '{32'h1000_0000, HTRANS_IDLE,   1'b0, -1};
    vt[7]  = '{32'h6000_0000, HTRANS_BUSY,   1'b0, -1};
    vt[8]  = '{32'h0007_FFFC, HTRANS_NONSEQ, 1'b0,  3};
    vt[9]  = '{32'h0008_0000, HTRANS_NONSEQ, 1'b0, -1};
    vt[10] = '{32'h207F_FFFC, HTRANS_NONSEQ, 1'b0,  2};
    vt[11] = '{32'h2080_0000, HTRANS_NONSEQ, 1'b0, -1};
    vt[12] = '{32'h600F_FFFC, HTRANS_NONSEQ, 1'b0,  0};
    vt[13] = '{32'h6010_0000, HTRANS_NONSEQ, 1'b0, -1};
    vt[14] = '{32'h4FFF_FFFC, HTRANS_SEQ,    1'b0,  1};

    // Reset state
    repeat (2) @(posedge clk);
    exp_cyc("reset_held", '0, 1'b1, HRESP_OKAY, '0);
    @(posedge clk); #1; rst = 1'b0;
    exp_cyc("reset_state", '0, 1'b1, HRESP_OKAY, '0);

    // Table: one address phase each, data-phase responses via scoreboard.
    for (int v = 0; v < 15; v++) begin
      logic [NS-1:0] hs;
      logic          act;
      act = vt[v].trans[1];
      hs  = (act && vt[v].slv >= 0) ? NS'(1 << vt[v].slv) : '0;
      nxt(vt[v].addr, vt[v].trans, vt[v].deny);
      @(negedge clk);
      chk($sformatf("vec%0d.hsel", v),  64'(s_hsel),  64'(hs));
      chk($sformatf("vec%0d.haddr", v), 64'(s_haddr), 64'(vt[v].addr));
      if (act && vt[v].slv < 0) begin
        sb.push_back('{1'b0, HRESP_ERROR, 32'h0});
        sb.push_back('{1'b1, HRESP_ERROR, 32'h0});
      end else if (act) begin
        sb.push_back('{1'b1, HRESP_OKAY, sdat(vt[v].slv)});
      end else begin
        sb.push_back('{1'b1, HRESP_OKAY, 32'h0});
      end
      while (sb.size() > 0) begin
        nxt(32'h0, HTRANS_IDLE, 1'b0);
        @(negedge clk);
        e = sb.pop_front();
        chk($sformatf("vec%0d.hready", v), 64'(m_hready), 64'(e.rdy));
        chk($sformatf("vec%0d.hresp", v),  64'(m_hresp),  64'(e.resp));
        chk($sformatf("vec%0d.hrdata", v), 64'(m_hrdata), 64'(e.rdata));
      end
    end

    // Pipelined write slave2 -> read slave1 (3 waits) -> read slave0 held.
    nxt(32'h2000_0004, HTRANS_NONSEQ, 1'b0); m_hwrite = 1'b1;
    @(negedge clk); chk("b2b.hwrite", 64'(s_hwrite), 64'd1);
    chk("b2b.c0.hsel", 64'(s_hsel), 64'b0100);
    nxt(32'h4000_0000, HTRANS_NONSEQ, 1'b0);
    exp_cyc("b2b.c1", 4'b0010, 1'b1, HRESP_OKAY, sdat(2));
    for (int k = 0; k < 3; k++) begin
      nxt(32'h6000_0000, HTRANS_NONSEQ, 1'b0); s_hready = 4'b1101;
      exp_cyc($sformatf("b2b.wait%0d", k), 4'b0001, 1'b0, HRESP_OKAY, sdat(1));
    end
    nxt(32'h6000_0000, HTRANS_NONSEQ, 1'b0); s_hready = '1;
    exp_cyc("b2b.c5", 4'b0001, 1'b1, HRESP_OKAY, sdat(1));
    nxt(32'h0, HTRANS_IDLE, 1'b0);
    exp_cyc("b2b.c6", '0, 1'b1, HRESP_OKAY, sdat(0));
    nxt(32'h0, HTRANS_IDLE, 1'b0);
    exp_cyc("b2b.c7", '0, 1'b1, HRESP_OKAY, '0);

    // Default slave back-to-back: new request accepted in ERR2.
    nxt(32'h1000_0000, HTRANS_NONSEQ, 1'b0);
    exp_cyc("dd.c0", '0, 1'b1, HRESP_OKAY, '0);
    nxt(32'h1000_0000, HTRANS_NONSEQ, 1'b0);
    exp_cyc("dd.c1", '0, 1'b0, HRESP_ERROR, '0);
    nxt(32'h1000_0000, HTRANS_NONSEQ, 1'b0);
    exp_cyc("dd.c2", '0, 1'b1, HRESP_ERROR, '0);
    nxt(32'h0, HTRANS_IDLE, 1'b0);
    exp_cyc("dd.c3", '0, 1'b0, HRESP_ERROR, '0);
    nxt(32'h0, HTRANS_IDLE, 1'b0);
    exp_cyc("dd.c4", '0, 1'b1, HRESP_ERROR, '0);
    nxt(32'h0, HTRANS_IDLE, 1'b0);
    exp_cyc("dd.c5", '0, 1'b1, HRESP_OKAY, '0);

    // Slave-generated ERROR passes through unaltered.
    nxt(32'h6000_0000, HTRANS_NONSEQ, 1'b0);
    exp_cyc("serr.c0", 4'b0001, 1'b1, HRESP_OKAY, '0);
    nxt(32'h0, HTRANS_IDLE, 1'b0); s_hready = 4'b1110; s_hresp = 8'b0000_0001;
    exp_cyc("serr.c1", '0, 1'b0, HRESP_ERROR, sdat(0));
    nxt(32'h0, HTRANS_IDLE, 1'b0); s_hready = '1;
    exp_cyc("serr.c2", '0, 1'b1, HRESP_ERROR, sdat(0));
    nxt(32'h0, HTRANS_IDLE, 1'b0); s_hresp = '0;
    exp_cyc("serr.c3", '0, 1'b1, HRESP_OKAY, '0);

    // Reset during a slave wait abandons the transfer.
    nxt(32'h4000_0000, HTRANS_NONSEQ, 1'b0);
    exp_cyc("rst.c0", 4'b0010, 1'b1, HRESP_OKAY, '0);
    nxt(32'h0, HTRANS_IDLE, 1'b0); s_hready = 4'b1101;
    exp_cyc("rst.c1", '0, 1'b0, HRESP_OKAY, sdat(1));
    nxt(32'h0, HTRANS_IDLE, 1'b0); rst = 1'b1;
    exp_cyc("rst.c2", '0, 1'b0, HRESP_OKAY, sdat(1));
    nxt(32'h0, HTRANS_IDLE, 1'b0); rst = 1'b0;
    exp_cyc("rst.c3", '0, 1'b1, HRESP_OKAY, '0);
    nxt(32'h0, HTRANS_IDLE, 1'b0); s_hready = '1;
    exp_cyc("rst.c4", '0, 1'b1, HRESP_OKAY, '0);

`ifdef AHB_DEC_MUX_TIMEOUT_EN
    // Slave1 hangs: 8 wait cycles, then a two-cycle ERROR and the window
    // stays fenced off until slave1 raises hready.
    nxt(32'h4000_0000, HTRANS_NONSEQ, 1'b0);
    exp_cyc("to.c0", 4'b0010, 1'b1, HRESP_OKAY, '0);
    for (int k = 1; k <= 8; k++) begin
      nxt(32'h0, HTRANS_IDLE, 1'b0); s_hready = 4'b1101;
      exp_cyc($sformatf("to.stall%0d", k), '0, 1'b0, HRESP_OKAY, sdat(1));
    end
    nxt(32'h0, HTRANS_IDLE, 1'b0);
    exp_cyc("to.err1", '0, 1'b0, HRESP_ERROR, '0);
    nxt(32'h4000_0004, HTRANS_NONSEQ, 1'b0);
    exp_cyc("to.err2", '0, 1'b1, HRESP_ERROR, '0);
    nxt(32'h0, HTRANS_IDLE, 1'b0);
    exp_cyc("to.orph1", '0, 1'b0, HRESP_ERROR, '0);
    nxt(32'h0, HTRANS_IDLE, 1'b0);
    exp_cyc("to.orph2", '0, 1'b1, HRESP_ERROR, '0);
    nxt(32'h4000_0008, HTRANS_IDLE, 1'b0); s_hready = '1;
    exp_cyc("to.recover", '0, 1'b1, HRESP_OKAY, '0);
    nxt(32'h4000_0000, HTRANS_NONSEQ, 1'b0);
    exp_cyc("to.resel", 4'b0010, 1'b1, HRESP_OKAY, '0);
    nxt(32'h0, HTRANS_IDLE, 1'b0);
    exp_cyc("to.data", '0, 1'b1, HRESP_OKAY, sdat(1));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_dec_mux.md
Name: ahb_dec_mux

Overview:
- Single-master AHB-Lite address decoder and response multiplexer with NUM_SLV parametrised slave windows.
- Contains a built-in default slave that returns a spec-compliant two-cycle ERROR for unmapped or denied accesses.
- Sits between the CPU BIU master port and the SMEM/APB-bridge/DMEM/peripheral slaves.
- Registers a data-phase select so address and data phases of different slaves pipeline correctly.

Parameters:
- NUM_SLV, 4: number of external slaves, 1..8.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- SLV_BASE, {32'h00000000,32'h20000000,32'h40000000,32'h60000000}: packed NUM_SLV*ADDR_W vector of per-slave base addresses; slave i occupies slice i.
- SLV_MASK, {32'hFFF80000,32'hFF800000,32'hF0000000,32'hFFF00000}: packed per-slave compare masks.
- TIMEOUT_CYC, 256: stall limit in cycles; used only with the optional feature.

Ports:
- pll_core_cpuclk  in  1  clock.
- pad_cpu_rst  in  1  reset, synchronous, active-high.
- m_haddr  in  ADDR_W  master address.
- m_htrans  in  2  master transfer type.
- m_hwrite  in  1  master write.
- m_hsize  in  3  master size.
- m_hburst  in  3  master burst.
- m_hprot  in  4  master protection.
- m_hwdata  in  DATA_W  master write data.
- smpu_deny  in  1  MPU deny for the current address phase.
- m_hrdata  out  DATA_W  muxed read data.
- m_hready  out  1  muxed ready.
- m_hresp  out  2  muxed response.
- s_hsel  out  NUM_SLV  per-slave select.
- s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst, s_hprot, s_hwdata  out  as master  broadcast copies of the master signals.
- s_hreadyin  out  1  equals m_hready.
- s_hrdata  in  NUM_SLV*DATA_W  slave read data.
- s_hready  in  NUM_SLV  slave ready.
- s_hresp  in  NUM_SLV*2  slave response.

Behaviour:
- Encodings: HTRANS IDLE=00, BUSY=01, NONSEQ=10, SEQ=11. HRESP OKAY=00, ERROR=01.
- Decode: hit[i] = ((m_haddr & SLV_MASK[i]) == SLV_BASE[i]). If several slaves hit, the lowest index wins.
- s_hsel[i] = m_htrans[1] & hit_pri[i] & ~smpu_deny. This is combinational; slaves qualify it with s_hreadyin.
- Address phase is accepted when m_htrans[1] & m_hready.
- Default-slave request: an accepted phase with no hit, or with smpu_deny=1.
- dsel is a registered one-hot of width NUM_SLV+1; bit NUM_SLV is the default slave.
  - Updated only when m_hready=1.
  - Loads the decoded select if a phase is accepted, otherwise all zeros.
- Response mux:
  - dsel one-hot slave i: pass s_hrdata[i], s_hready[i], s_hresp[i] to the master.
  - dsel = default slave: output of the default-slave FSM, with hrdata = 0.
  - dsel = 0: hready=1, hresp=OKAY, hrdata=0.
- Default-slave FSM states DS_IDLE, DS_ERR1, DS_ERR2:
  - IDLE -> ERR1 on a default-slave request.
  - ERR1 drives hready=0, hresp=ERROR; always -> ERR2.
  - ERR2 drives hready=1, hresp=ERROR; -> ERR1 if another default request is accepted this cycle, else IDLE.
- IDLE/BUSY to any address: zero-wait OKAY; no slave is selected.
- Back-to-back transfers to different slaves: the new address phase is accepted in the same cycle the old data phase completes, so there are no bubbles.
- Reset state: dsel=0, FSM=DS_IDLE, m_hready=1, m_hresp=00, m_hrdata=0. The timeout counter and orphan flags are also 0.
- Reset asserted mid-transfer: all state clears on the next edge and the in-flight transfer is abandoned. Slaves share the same reset.
- Slave ERROR first cycle (hready=0, ERROR) is passed through unaltered.

Optional Feature:
- Macro: AHB_DEC_MUX_TIMEOUT_EN.
- Defined:
  - A stall counter of width $clog2(TIMEOUT_CYC+1) increments while dsel selects an external slave and m_hready=0. It clears whenever m_hready=1.
  - When count reaches TIMEOUT_CYC, the block overrides that slave's response with a two-cycle ERROR (cycle 1 hready=0, cycle 2 hready=1) and sets orphan[i].
  - While orphan[i]=1, s_hsel[i] is forced to 0 and accesses to slave i route to the default slave (ERROR).
  - orphan[i] clears on the first cycle s_hready[i]=1.
- Not defined: no counter, no orphan logic; the master waits indefinitely.

Decomposition:
- ahb_pkg holds HTRANS/HRESP constants and the default-slave state enum.
- ahb_pkg also holds a decode function taking (addr, base, mask).
- One sub-module, ahb_default_slave: the FSM plus its hready/hresp outputs.

Test Plan:
- NONSEQ read 0x60000010, slave0 hready=1: s_hsel=0001 in the address cycle; next cycle m_hrdata equals s_hrdata[0], OKAY.
- NONSEQ to 0x10000000 (unmapped): cycle+1 hready=0/ERROR, cycle+2 hready=1/ERROR, no s_hsel asserted.
- Write to 0x20000004 followed by read to 0x40000000, slave2 inserting 3 waits: s_hsel[1] held until m_hready=1, no lost or duplicated select.
- smpu_deny=1 with 0x20000000: s_hsel=0, two-cycle ERROR; IDLE to 0x10000000: OKAY, zero wait.
- Reset asserted during a slave wait: next edge m_hready=1, dsel=0, FSM IDLE.
- TIMEOUT_EN, TIMEOUT_CYC=8, slave1 stalls forever: ERROR after 8 stall cycles; next access to 0x4xxxxxxx gives ERROR until s_hready[1]=1.
